seq_shift_add_multiplier: RTL and testbench

- Iterative shift-add integer multiplier for the KGP-RISC ALU multi-cycle datapath.
- Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, in unsigned or two's-complement signed mode.
- Retires BITS_PER_CYCLE multiplier bits per clock, with a start/busy/done handshake so the control unit can stall on multiply instructions.

---
 rtl/seq_shift_add_multiplier.sv | 109 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per clock and
// produces the full 2*WIDTH-bit product, unsigned or two's-complement signed.
`timescale 1ns/1ps
module seq_shift_add_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_EXIT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0]   product_reg;
  logic [WIDTH-1:0]     mplr_reg;
  logic [CW-1:0]        count_reg;
  logic                 neg_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplr_next;
  logic [CW-1:0]        count_next;
  logic                 finish;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   term [BITS_PER_CYCLE];

  // mcand_reg is kept pre-shifted by count*BITS_PER_CYCLE, so term gi only adds the lane offset
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
    assign term[gi] = mplr_reg[gi] ? (mcand_reg << gi) : '0;
  end

  always_comb begin
    acc_next = acc_reg;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      acc_next = acc_next + term[k];
    end
  end

  assign mplr_next  = mplr_reg >> BITS_PER_CYCLE;
  assign count_next = count_reg + CW'(1);
  assign finish     = (count_next == CW'(N)) || ((EARLY_EXIT != 0) && (mplr_next == '0));

  // The most negative value maps onto itself, which is already its correct unsigned magnitude
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      product_reg <= '0;
      mplr_reg    <= '0;
      count_reg   <= '0;
      neg_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            acc_reg   <= '0;
            count_reg <= '0;
            mplr_reg  <= a_mag;
            mcand_reg <= {{WIDTH{1'b0}}, b_mag};
            neg_reg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          mplr_reg  <= mplr_next;
          mcand_reg <= mcand_reg << BITS_PER_CYCLE;
          count_reg <= count_next;
          if (finish) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            product_reg <= neg_reg ? -acc_next : acc_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: three instances (fixed latency, early exit at
// 1 and 4 bits/cycle) checked every cycle against an arithmetic model plus literal vectors.
`timescale 1ns/1ps
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start     [3];
  logic        is_signed [3];
  logic [31:0] a         [3];
  logic [31:0] b         [3];
  logic        busy      [3];
  logic        done      [3];
  logic [63:0] product   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_EXIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .is_signed(is_signed[0]),
    .a(a[0]), .b(b[0]), .busy(busy[0]), .done(done[0]), .product(product[0]));

  seq_shift_add_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_EXIT(1)) dut_ee1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .is_signed(is_signed[1]),
    .a(a[1]), .b(b[1]), .busy(busy[1]), .done(done[1]), .product(product[1]));

  seq_shift_add_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_EXIT(1)) dut_ee4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .is_signed(is_signed[2]),
    .a(a[2]), .b(b[2]), .busy(busy[2]), .done(done[2]), .product(product[2]));

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int bpc_of(input int i);
    return (i == 2) ? 4 : 1;
  endfunction

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic int ref_lat(input int i, input logic s, input logic [31:0] x);
    logic [31:0] mag;
    int msb, bpc, m;
    bpc = bpc_of(i);
    if (i == 0) return 32 / bpc;
    mag = (s && x[31]) ? -x : x;
    msb = -1;
    for (int k = 0; k < 32; k++) if (mag[k]) msb = k;
    m = (msb + 1 + bpc - 1) / bpc;
    return (m < 1) ? 1 : m;
  endfunction

  // Model: a countdown of the expected number of edges, with the product from plain arithmetic
  logic        m_busy [3];
  logic        m_done [3];
  logic [63:0] m_prod [3];
  logic [63:0] m_exp  [3];
  int          m_left [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_prod[i] <= '0; m_exp[i] <= '0; m_left[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (start[i]) begin
            m_busy[i] <= 1'b1;
            m_left[i] <= ref_lat(i, is_signed[i], a[i]);
            m_exp[i]  <= ref_mul(is_signed[i], a[i], b[i]);
          end
        end else if (m_left[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_prod[i] <= m_exp[i];
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cyc_busy%0d", i), {63'b0, busy[i]}, {63'b0, m_busy[i]});
        check($sformatf("cyc_done%0d", i), {63'b0, done[i]}, {63'b0, m_done[i]});
        check($sformatf("cyc_prod%0d", i), product[i], m_prod[i]);
      end
    end
  end

  task automatic do_op(input int i, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp, input int exp_edges, input string nm);
    int edges, busy_cnt;
    @(negedge clk);
    start[i] = 1'b1; is_signed[i] = s; a[i] = av; b[i] = bv;
    @(posedge clk);
    #1 start[i] = 1'b0;
    busy_cnt = busy[i] ? 1 : 0;
    edges = 0;
    do begin
      @(posedge clk); edges++; #1;
      if (busy[i]) busy_cnt++;
    end while (!done[i] && edges < 200);
    check({nm, "_prod"}, product[i], exp);
    check({nm, "_lat"}, 64'(edges), 64'(exp_edges));
    if (i == 0) check({nm, "_busycyc"}, 64'(busy_cnt), 64'(exp_edges));
    $display("op %s inst=%0d a=%h b=%h signed=%0d product=%h edges=%0d", nm, i, av, bv, s, product[i], edges);
  endtask

  initial begin
    int edges;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; is_signed[i] = 1'b0; a[i] = '0; b[i] = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), {63'b0, busy[i]}, 64'd0);
      check($sformatf("rst_done%0d", i), {63'b0, done[i]}, 64'd0);
      check($sformatf("rst_prod%0d", i), product[i], 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    do_op(0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32, "umax");
    do_op(0, 1'b1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFFFFFFFFEB, 32, "smix");
    do_op(0, 1'b0, 32'hFFFFFFFD, 32'd7,        64'h00000006FFFFFFEB, 32, "umix");
    do_op(0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32, "sminsq");
    do_op(0, 1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF80000000, 32, "smin1");
    do_op(0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFA, 64'd30,               32, "snegneg");

    // Handshake: start during busy is ignored, start in the done cycle is accepted
    @(negedge clk);
    start[0] = 1'b1; is_signed[0] = 1'b0; a[0] = 32'd6; b[0] = 32'd7;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); start[0] = 1'b1; a[0] = 32'd100; b[0] = 32'd100;
    @(negedge clk); start[0] = 1'b0;
    edges = 0;
    do begin @(posedge clk); edges++; #1; end while (!done[0] && edges < 200);
    check("hs_first_prod", product[0], 64'd42);
    start[0] = 1'b1; a[0] = 32'd3; b[0] = 32'd5;
    @(posedge clk); #1 start[0] = 1'b0;
    check("hs_done_falls", {63'b0, done[0]}, 64'd0);
    check("hs_busy_again", {63'b0, busy[0]}, 64'd1);
    edges = 0;
    do begin @(posedge clk); edges++; #1; end while (!done[0] && edges < 200);
    check("hs_second_prod", product[0], 64'd15);
    check("hs_second_lat", 64'(edges), 64'd32);
    $display("op handshake product=%h edges=%0d", product[0], edges);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    start[0] = 1'b1; a[0] = 32'd10; b[0] = 32'd10;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, busy[0]}, 64'd0);
    check("midrst_done", {63'b0, done[0]}, 64'd0);
    check("midrst_prod", product[0], 64'd0);
    @(negedge clk); rst_n = 1'b1;
    edges = 0;
    repeat (40) begin @(posedge clk); #1; if (done[0]) edges++; end
    check("midrst_nodone", 64'(edges), 64'd0);
    $display("op midreset done_pulses_after_release=%0d", edges);

    do_op(1, 1'b0, 32'd5,        32'd9,  64'd45,          3, "ee1_5x9");
    do_op(1, 1'b0, 32'd0,        32'd9,  64'd0,           1, "ee1_0x9");
    do_op(1, 1'b1, 32'hFFFFFFFF, 32'd9,  64'hFFFFFFFFFFFFFFF7, 1, "ee1_m1x9");
    do_op(2, 1'b0, 32'h00000100, 32'd3,  64'h300,         3, "ee4_256x3");
    do_op(2, 1'b0, 32'hFFFFFFFF, 32'd2,  64'h1FFFFFFFE,   8, "ee4_maxx2");
    do_op(2, 1'b1, 32'hFFFFFFF0, 32'd3,  64'hFFFFFFFFFFFFFFD0, 2, "ee4_m16x3");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
